mcpu_core_regfile_sb: RTL
=========================

Name: mcpu_core_regfile_sb

Overview:
Parametrised multi-lane register file for the Moroso core, sitting between decode (reads) and writeback (writes). It generalises lane count, data width, register count and predicate count. It adds optional same-cycle write-to-read bypass and a per-register pending scoreboard, so decode can detect RAW hazards on in-flight destinations. The scoreboard is set by decode claims, cleared by writeback and wiped by a pipeline flush.

Parameters:
LANES, 4, number of issue lanes; each lane has 2 read ports (rs, rt) and 1 write port
DATA_W, 32, register data width
NREGS, 32, number of GPRs, power of two; RA_W = log2(NREGS) is derived
NPREDS, 3, number of predicate bits; PA_W = max(1, ceil(log2(NPREDS))) is derived
BYPASS, 1, 1 = read ports see same-cycle writeback data and predicates; 0 = reads see stored state only

Ports:
clkrst_core_clk  in  1  core clock, all state on rising edge
clkrst_core_rst  in  1  asynchronous, active-high reset
wb2rf_rd_num  in  LANES*RA_W  per-lane destination register; lane i occupies slice i
wb2rf_rd_data  in  LANES*DATA_W  per-lane writeback data
wb2rf_rd_we  in  LANES  per-lane GPR write enable; also clears that register's pending bit
wb2rf_pred_we  in  LANES  per-lane predicate write enable; index = rd_num[PA_W-1:0], value = rd_data[0]
d2rf_rs_num, d2rf_rt_num  in  LANES*RA_W each  read addresses
rf2d_rs_data, rf2d_rt_data  out  LANES*DATA_W each  read data, combinational
rf2d_rs_busy, rf2d_rt_busy  out  LANES each  pending flag of the addressed register
d2rf_claim_we  in  LANES  per-lane scoreboard claim enable
d2rf_claim_num  in  LANES*RA_W  register to mark pending
flush  in  1  synchronous clear of all pending bits
preds  out  NPREDS  predicate register, registered
pending  out  NREGS  raw scoreboard vector, registered
r0  out  DATA_W  register 0 contents, debug

Behaviour:
- Reset (async, rst=1): all GPRs = 0, preds = 0, pending = 0. Outputs reflect these values immediately, without waiting for a clock edge. Release is sampled on the next clock.
- GPR write: registered, visible in storage after 1 edge. If several lanes write the same register in one cycle, the lowest-numbered lane wins. r0 is an ordinary writable register.
- Predicate write: follows the same lowest-lane-wins rule. An index >= NPREDS is silently ignored, with no effect and no error. pred_we is independent of rd_we.
- Reads: combinational from storage.
- BYPASS=1: if any lane has rd_we=1 with rd_num equal to the read address in the same cycle, the read returns the data of the lowest such lane. preds is always the registered value; bypass applies only to GPR reads.
- Scoreboard next state, evaluated per register r, in priority order:
  1. flush=1 → 0.
  2. Else any claim lane targets r → 1. A claim beats a same-cycle clear, because a newer producer has been issued.
  3. Else any wb lane with rd_we targets r → 0.
  4. Else hold.
- Busy outputs:
  - busy = pending[addr].
  - If BYPASS=1 and a wb lane writes addr this cycle, busy = 0, since the data is being forwarded.
  - A same-cycle claim does not raise busy until the next cycle.
- Latency: read 0 cycles; write, predicate, claim and clear visible in storage after 1 cycle.
- Widths: no arithmetic. Slices are packed LSB-first, lane 0 in the lowest bits.

Test Plan:
- Reset then idle → every rs/rt data = 0, preds = 0, pending = 0. Pulse rst mid-stream after writing r5=0xDEADBEEF → r5 reads 0 within the same cycle, with no clock edge.
- Lanes 0 and 2 both write r7 (0x11111111, 0x22222222) → next cycle r7 = 0x11111111. With BYPASS=1, the same-cycle read of r7 also returns 0x11111111.
- BYPASS=0, lane 1 writes r3=0xA5A5A5A5 while rs0 reads r3 (old value 0) → rs_data0 = 0 this cycle, 0xA5A5A5A5 the next cycle.
- pred_we on lane 0 with idx 1, data bit 1, plus lane 3 with idx 3 → preds = 3'b010; idx 3 is ignored.
- Claim r9 → pending[9] = 1 next cycle and rs_busy = 1 for r9.
  - Same cycle: claim r9 on lane 0 and wb r9 on lane 1 → pending[9] stays 1.
  - Next cycle: wb r9 alone → busy 0 immediately (BYPASS=1) and pending[9] = 0 the cycle after.
- Claim r4, r6, r8, then flush with a simultaneous claim of r10 → pending = 0 next cycle; flush wins over the claim.

Source files
------------

// File: rtl/mcpu_core_regfile_sb_if.sv
// Decode/writeback bus bundle for the Moroso multi-lane register file.
// Lane i occupies slice i of every packed field, lane 0 in the low bits.
interface mcpu_core_regfile_sb_if #(
  parameter int LANES  = 4,
  parameter int DATA_W = 32,
  parameter int NREGS  = 32
);
  localparam int RA_W = $clog2(NREGS);

  logic [LANES*RA_W-1:0]   wb2rf_rd_num;
  logic [LANES*DATA_W-1:0] wb2rf_rd_data;
  logic [LANES-1:0]        wb2rf_rd_we;
  logic [LANES-1:0]        wb2rf_pred_we;
  logic [LANES*RA_W-1:0]   d2rf_rs_num;
  logic [LANES*RA_W-1:0]   d2rf_rt_num;
  logic [LANES-1:0]        d2rf_claim_we;
  logic [LANES*RA_W-1:0]   d2rf_claim_num;
  logic [LANES*DATA_W-1:0] rf2d_rs_data;
  logic [LANES*DATA_W-1:0] rf2d_rt_data;
  logic [LANES-1:0]        rf2d_rs_busy;
  logic [LANES-1:0]        rf2d_rt_busy;

  modport master (
    output wb2rf_rd_num, wb2rf_rd_data,
    output wb2rf_rd_we, wb2rf_pred_we,
    output d2rf_rs_num, d2rf_rt_num,
    output d2rf_claim_we, d2rf_claim_num,
    input  rf2d_rs_data, rf2d_rt_data,
    input  rf2d_rs_busy, rf2d_rt_busy
  );

  modport slave (
    input  wb2rf_rd_num, wb2rf_rd_data,
    input  wb2rf_rd_we, wb2rf_pred_we,
    input  d2rf_rs_num, d2rf_rt_num,
    input  d2rf_claim_we, d2rf_claim_num,
    output rf2d_rs_data, rf2d_rt_data,
    output rf2d_rs_busy, rf2d_rt_busy
  );
endinterface

// File: rtl/mcpu_core_regfile_sb.sv
// Multi-lane GPR/predicate register file with optional writeback bypass
// and a per-register pending scoreboard for decode RAW detection.
module mcpu_core_regfile_sb #(
  parameter int LANES  = 4,
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  parameter int NPREDS = 3,
  parameter int BYPASS = 1
) (
  input  logic                  clkrst_core_clk,
  input  logic                  clkrst_core_rst,
  mcpu_core_regfile_sb_if.slave rf,
  input  logic                  flush,
  output logic [NPREDS-1:0]     preds,
  output logic [NREGS-1:0]      pending,
  output logic [DATA_W-1:0]     r0
);
  localparam int RA_W = $clog2(NREGS);
  localparam int PA_W = (NPREDS > 1) ? $clog2(NPREDS) : 1;

  typedef logic [RA_W-1:0]   ra_t;
  typedef logic [DATA_W-1:0] dw_t;

  ra_t wnum [LANES];
  ra_t rs_a [LANES];
  ra_t rt_a [LANES];
  ra_t cnum [LANES];
  dw_t wdat [LANES];

  dw_t regs_q [NREGS];
  dw_t regs_d [NREGS];

  logic [NPREDS-1:0] preds_q, preds_d;
  logic [NREGS-1:0]  pend_q, pend_d;

  logic [LANES*DATA_W-1:0] rs_data, rt_data;
  logic [LANES-1:0]        rs_busy, rt_busy;

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      wnum[l] = rf.wb2rf_rd_num[l*RA_W +: RA_W];
      rs_a[l] = rf.d2rf_rs_num[l*RA_W +: RA_W];
      rt_a[l] = rf.d2rf_rt_num[l*RA_W +: RA_W];
      cnum[l] = rf.d2rf_claim_num[l*RA_W +: RA_W];
      wdat[l] = rf.wb2rf_rd_data[l*DATA_W +: DATA_W];
    end
  end

  // Walk lanes high to low so the lowest lane's write lands last.
  always_comb begin
    regs_d = regs_q;
    for (int l = LANES - 1; l >= 0; l--) begin
      if (rf.wb2rf_rd_we[l]) begin
        regs_d[wnum[l]] = wdat[l];
      end
    end
  end

  always_comb begin
    logic [PA_W-1:0] pidx;
    pidx    = '0;
    preds_d = preds_q;
    for (int l = LANES - 1; l >= 0; l--) begin
      pidx = wnum[l][PA_W-1:0];
      if (rf.wb2rf_pred_we[l] && (int'(pidx) < NPREDS)) begin
        preds_d[pidx] = wdat[l][0];
      end
    end
  end

  // Later assignments win: flush over claim over writeback clear.
  always_comb begin
    pend_d = pend_q;
    for (int l = 0; l < LANES; l++) begin
      if (rf.wb2rf_rd_we[l]) begin
        pend_d[wnum[l]] = 1'b0;
      end
    end
    for (int l = 0; l < LANES; l++) begin
      if (rf.d2rf_claim_we[l]) begin
        pend_d[cnum[l]] = 1'b1;
      end
    end
    if (flush) begin
      pend_d = '0;
    end
  end

  // A forwarded operand is never busy: its producer is retiring now.
  always_comb begin
    rs_data = '0;
    rt_data = '0;
    rs_busy = '0;
    rt_busy = '0;
    for (int i = 0; i < LANES; i++) begin
      rs_data[i*DATA_W +: DATA_W] = regs_q[rs_a[i]];
      rt_data[i*DATA_W +: DATA_W] = regs_q[rt_a[i]];
      rs_busy[i] = pend_q[rs_a[i]];
      rt_busy[i] = pend_q[rt_a[i]];
      if (BYPASS != 0) begin
        for (int l = LANES - 1; l >= 0; l--) begin
          if (rf.wb2rf_rd_we[l] && (wnum[l] == rs_a[i])) begin
            rs_data[i*DATA_W +: DATA_W] = wdat[l];
            rs_busy[i] = 1'b0;
          end
          if (rf.wb2rf_rd_we[l] && (wnum[l] == rt_a[i])) begin
            rt_data[i*DATA_W +: DATA_W] = wdat[l];
            rt_busy[i] = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clkrst_core_clk or posedge clkrst_core_rst) begin
    if (clkrst_core_rst) begin
      regs_q  <= '{default: '0};
      preds_q <= '0;
      pend_q  <= '0;
    end else begin
      regs_q  <= regs_d;
      preds_q <= preds_d;
      pend_q  <= pend_d;
    end
  end

  assign rf.rf2d_rs_data = rs_data;
  assign rf.rf2d_rt_data = rt_data;
  assign rf.rf2d_rs_busy = rs_busy;
  assign rf.rf2d_rt_busy = rt_busy;

  assign preds   = preds_q;
  assign pending = pend_q;
  assign r0      = regs_q[0];

endmodule
